// File: rtl/pe_array_pkg.sv
// Shared constants for the PE array and its control sequencer.
// Holds the array phase codes, default widths and the sequencer's state encodings.
// No logic; a helper maps sequencer states onto the phase code broadcast to the array.
package pe_array_pkg;

    // Phase codes seen by every PE on global_state
    localparam logic [1:0] S_LOAD_W = 2'd0;
    localparam logic [1:0] S_LOAD_X = 2'd1;
    localparam logic [1:0] S_MAC    = 2'd2;
    localparam logic [1:0] S_IDLE   = 2'd3;

    // Default array geometry and data width
    localparam int DW_DEF    = 8;
    localparam int ROW_W_DEF = 4;
    localparam int COL_W_DEF = 4;

    // Sequencer FSM encodings
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD_W  = 3'd1;
    localparam logic [2:0] ST_W_DRAIN = 3'd2;
    localparam logic [2:0] ST_WAIT_X  = 3'd3;
    localparam logic [2:0] ST_LOAD_X  = 3'd4;
    localparam logic [2:0] ST_MAC     = 3'd5;
    localparam logic [2:0] ST_CAPTURE = 3'd6;
    localparam logic [2:0] ST_DONE    = 3'd7;

    // W_DRAIN keeps the load phase so the final weight strobe lands while PEs still accept writes
    function automatic logic [1:0] phase_of(input logic [2:0] st);
        case (st)
            ST_LOAD_W, ST_W_DRAIN: return S_LOAD_W;
            ST_LOAD_X:             return S_LOAD_X;
            ST_MAC:                return S_MAC;
            default:               return S_IDLE;
        endcase
    endfunction

    // Job lengths of zero are promoted to one
    function automatic logic [15:0] at_least_one(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

endpackage

// File: rtl/pe_cfg_addr_gen.sv
// Row-major {row,col} address counter for weight configuration writes.
// Address updates one cycle after an advance; clear takes effect next cycle.
// Holds at the last populated PE, so unpopulated addresses are never produced.
module pe_cfg_addr_gen #(
    parameter int ROW_W = 4,
    parameter int COL_W = 4,
    parameter int ROWS  = 4,
    parameter int COLS  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   adv,
    output logic [ROW_W+COL_W-1:0] addr,
    output logic                   last
);

    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;

    // Walk columns first, then wrap to the next row; freeze on the last PE
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            row <= '0;
            col <= '0;
        end else if (adv && !last) begin
            if (col == COL_W'(COLS - 1)) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign addr = {row, col};
    assign last = (row == ROW_W'(ROWS - 1)) && (col == COL_W'(COLS - 1));

endmodule

// File: rtl/pe_array_seq.sv
// Sequencer driving PE array weight writes and LOAD_W/LOAD_X/MAC phase broadcast.
// All outputs registered: weight strobe one cycle after handshake, phases track state.
// w_ready only in LOAD_W, x_ready only in WAIT_X; upstream holds valid until accepted.
module pe_array_seq
    import pe_array_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int ROW_W = ROW_W_DEF,
    parameter int COL_W = COL_W_DEF,
    parameter int ROWS  = 4,
    parameter int COLS  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [15:0]             mac_len,
    input  logic [15:0]             n_vec,
    input  logic                    w_valid,
    input  logic signed [DW-1:0]    w_data,
    output logic                    w_ready,
    input  logic                    x_valid,
    output logic                    x_ready,
    output logic [ROW_W+COL_W-1:0]  cfg_addr,
    output logic signed [DW-1:0]    cfg_data,
    output logic                    cfg_valid,
    output logic [1:0]              global_state,
    output logic                    acc_capture,
    output logic                    busy,
    output logic                    done
);

    logic [2:0]             st;
    logic [2:0]             st_nxt;
    logic [15:0]            mac_len_q;
    logic [15:0]            mac_cnt;
    logic [15:0]            vec_cnt;
    logic                   w_hs;
    logic                   x_hs;
    logic                   job_go;
    logic [ROW_W+COL_W-1:0] addr;
    logic                   addr_last;

    assign w_hs   = w_valid && w_ready;
    assign x_hs   = x_valid && x_ready;
    assign job_go = (st == ST_IDLE) && start;

    pe_cfg_addr_gen #(
        .ROW_W (ROW_W),
        .COL_W (COL_W),
        .ROWS  (ROWS),
        .COLS  (COLS)
    ) u_addr_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (job_go),
        .adv  (w_hs),
        .addr (addr),
        .last (addr_last)
    );

    // Next-state decode; start outside IDLE falls through untouched
    always_comb begin
        st_nxt = st;
        case (st)
            ST_IDLE:    if (start) st_nxt = ST_LOAD_W;
            ST_LOAD_W:  if (w_hs && addr_last) st_nxt = ST_W_DRAIN;
            ST_W_DRAIN: st_nxt = ST_WAIT_X;
            ST_WAIT_X:  if (x_hs) st_nxt = ST_LOAD_X;
            ST_LOAD_X:  st_nxt = ST_MAC;
            ST_MAC:     if (mac_cnt <= 16'd1) st_nxt = ST_CAPTURE;
            ST_CAPTURE: st_nxt = (vec_cnt <= 16'd1) ? ST_DONE : ST_WAIT_X;
            ST_DONE:    st_nxt = ST_IDLE;
            default:    st_nxt = ST_IDLE;
        endcase
    end

    // State, job counters and output registers; outputs are decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            st           <= ST_IDLE;
            mac_len_q    <= 16'd1;
            mac_cnt      <= '0;
            vec_cnt      <= '0;
            cfg_valid    <= 1'b0;
            cfg_addr     <= '0;
            cfg_data     <= '0;
            global_state <= S_IDLE;
            w_ready      <= 1'b0;
            x_ready      <= 1'b0;
            acc_capture  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            st <= st_nxt;

            if (job_go) begin
                mac_len_q <= at_least_one(mac_len);
                vec_cnt   <= at_least_one(n_vec);
            end

            if (st == ST_LOAD_X) begin
                mac_cnt <= mac_len_q;
            end else if (st == ST_MAC && mac_cnt != 16'd0) begin
                mac_cnt <= mac_cnt - 16'd1;
            end

            if (st == ST_CAPTURE && vec_cnt != 16'd0) begin
                vec_cnt <= vec_cnt - 16'd1;
            end

            cfg_valid <= w_hs;
            if (w_hs) begin
                cfg_addr <= addr;
                cfg_data <= w_data;
            end

            global_state <= phase_of(st_nxt);
            w_ready      <= (st_nxt == ST_LOAD_W);
            x_ready      <= (st_nxt == ST_WAIT_X);
            acc_capture  <= (st_nxt == ST_CAPTURE);
            busy         <= (st_nxt != ST_IDLE);
            done         <= (st_nxt == ST_DONE);
        end
    end

endmodule

// File: tb/tb_pe_array_seq.sv
module tb_pe_array_seq;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [15:0]       mac_len;
    logic [15:0]       n_vec;
    logic              w_valid;
    logic signed [7:0] w_data;
    logic              w_ready;
    logic              x_valid;
    logic              x_ready;
    logic [7:0]        cfg_addr;
    logic signed [7:0] cfg_data;
    logic              cfg_valid;
    logic [1:0]        global_state;
    logic              acc_capture;
    logic              busy;
    logic              done;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int gs0_cnt  = 0;
    int cap_cnt  = 0;
    int done_cnt = 0;
    logic [7:0] wa[$];
    logic [7:0] wd[$];

    always #5 clk = ~clk;

    pe_array_seq dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mac_len      (mac_len),
        .n_vec        (n_vec),
        .w_valid      (w_valid),
        .w_data       (w_data),
        .w_ready      (w_ready),
        .x_valid      (x_valid),
        .x_ready      (x_ready),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .cfg_valid    (cfg_valid),
        .global_state (global_state),
        .acc_capture  (acc_capture),
        .busy         (busy),
        .done         (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle and log what the DUT shows just after the edge
    task automatic step();
        @(posedge clk);
        #1;
        if (cfg_valid) begin
            wa.push_back(cfg_addr);
            wd.push_back(cfg_data);
        end
        if (global_state == 2'd0) gs0_cnt++;
        if (acc_capture) cap_cnt++;
        if (done) done_cnt++;
    endtask

    task automatic start_job(input logic [15:0] m, input logic [15:0] n);
        wa.delete();
        wd.delete();
        gs0_cnt  = 0;
        cap_cnt  = 0;
        done_cnt = 0;
        mac_len  = m;
        n_vec    = n;
        start    = 1'b1;
        step();
        start    = 1'b0;
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_wrdy", {31'd0, w_ready}, 32'd1);
    endtask

    // Push 16 weights base+1..base+16, optionally idling every other cycle
    task automatic load_weights(input bit toggle, input int base);
        int k = 0;
        int t = 0;
        bit hs;
        while (k < 16 && t < 100) begin
            w_valid = toggle ? t[0] : 1'b1;
            w_data  = 8'(base + k + 1);
            hs      = w_valid && w_ready;
            step();
            if (hs) k++;
            t++;
        end
        w_valid = 1'b0;
        chk("w_load_count", k, 16);
    endtask

    task automatic check_writes(input int base);
        chk("wr_total", wa.size(), 16);
        for (int i = 0; i < 16 && i < wa.size(); i++) begin
            chk($sformatf("wr_addr[%0d]", i), {24'd0, wa[i]}, ((i / 4) << 4) | (i % 4));
            chk($sformatf("wr_data[%0d]", i), {24'd0, wd[i]}, (base + i + 1) & 8'hff);
        end
    endtask

    task automatic wait_xready();
        int t = 0;
        while (!x_ready && t < 20) begin
            step();
            t++;
        end
        chk("x_ready_wait", {31'd0, x_ready}, 32'd1);
    endtask

    // One WAIT_X -> LOAD_X -> MAC -> CAPTURE round
    task automatic do_round(input int mac_exp, input int idle_cyc, input bit poke_start);
        int n2 = 0;
        wait_xready();
        for (int i = 0; i < idle_cyc; i++) begin
            step();
            chk("wait_gs", {30'd0, global_state}, 32'd3);
        end
        x_valid = 1'b1;
        step();
        x_valid = 1'b0;
        chk("ldx_gs", {30'd0, global_state}, 32'd1);
        chk("ldx_xrdy", {31'd0, x_ready}, 32'd0);
        if (poke_start) start = 1'b1;
        for (int i = 0; i < mac_exp; i++) begin
            step();
            if (global_state == 2'd2) n2++;
        end
        start = 1'b0;
        chk("mac_cycles", n2, mac_exp);
        step();
        chk("cap_pulse", {31'd0, acc_capture}, 32'd1);
        chk("cap_gs", {30'd0, global_state}, 32'd3);
    endtask

    task automatic finish_job();
        step();
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd1);
        step();
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_done", {31'd0, done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; mac_len = '0; n_vec = '0;
        w_valid = 1'b0; w_data = '0; x_valid = 1'b0;
        step();
        step();
        chk("rst_gs", {30'd0, global_state}, 32'd3);
        chk("rst_cfg_valid", {31'd0, cfg_valid}, 32'd0);
        chk("rst_cfg_addr", {24'd0, cfg_addr}, 32'd0);
        chk("rst_cfg_data", {24'd0, cfg_data}, 32'd0);
        chk("rst_wrdy", {31'd0, w_ready}, 32'd0);
        chk("rst_xrdy", {31'd0, x_ready}, 32'd0);
        chk("rst_cap", {31'd0, acc_capture}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        // Full load with constant valid, then a single 4-cycle vector
        start_job(16'd4, 16'd1);
        load_weights(1'b0, 0);
        chk("load_gs0_cycles", gs0_cnt, 17);
        check_writes(0);
        do_round(4, 5, 1'b0);
        finish_job();
        chk("a_caps", cap_cnt, 1);
        chk("a_dones", done_cnt, 1);

        // Backpressured load, three vectors reusing the same weights
        start_job(16'd2, 16'd3);
        load_weights(1'b1, 32);
        for (int r = 0; r < 3; r++) do_round(2, (r == 0) ? 2 : 0, 1'b0);
        finish_job();
        check_writes(32);
        chk("b_caps", cap_cnt, 3);
        chk("b_dones", done_cnt, 1);

        // Reset in the middle of a long MAC phase
        start_job(16'd20, 16'd1);
        load_weights(1'b0, 0);
        wait_xready();
        x_valid = 1'b1;
        step();
        x_valid = 1'b0;
        step();
        step();
        chk("pre_rst_mac", {30'd0, global_state}, 32'd2);
        rst = 1'b1;
        step();
        chk("mid_rst_gs", {30'd0, global_state}, 32'd3);
        chk("mid_rst_cfg_valid", {31'd0, cfg_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_wrdy", {31'd0, w_ready}, 32'd0);
        step();
        step();
        rst = 1'b0;
        cap_cnt = 0;
        repeat (25) step();
        chk("rst_idle_busy", {31'd0, busy}, 32'd0);
        chk("rst_idle_gs", {30'd0, global_state}, 32'd3);
        chk("rst_no_cap", cap_cnt, 0);

        // Zero lengths act as one; start during MAC must not spawn a job
        start_job(16'd0, 16'd0);
        load_weights(1'b0, 64);
        check_writes(64);
        do_round(1, 0, 1'b1);
        finish_job();
        repeat (4) step();
        chk("c_no_rejob", {31'd0, busy}, 32'd0);
        chk("c_caps", cap_cnt, 1);
        chk("c_dones", done_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
